// File: rtl/mem_port_responder.sv
// -----------------------------------------------------------------------------
// mem_port_responder
//
// Memory-side responder for one mem_handle port. Owns a single-port word SRAM
// (2^ADDR_W x DATA_W) and services single-word read/write requests from an
// FPU-side initiator, answering each with a one-cycle done pulse.
//
// Optional feature: define MEMRESP_BOUNDS_CHECK_EN to reject requests whose
// ptr lies outside [region_begin, region_end]. Without it every
// single-qualifier request reaches the SRAM. The region registers are still
// loadable and readable.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   avail            request valid (sampled only in IDLE)
//   r_en, w_en       read / write qualifiers (exactly one must be set)
//   ptr              absolute word address
//   data_store       write data
//   data_load        read data; non-zero only during a read done cycle
//   done             single-cycle completion pulse
//   err              raised with done when a request is rejected
//   region_begin/end inclusive address region (registered)
//   cfg_we           region load strobe; cfg_begin/cfg_end give the new bounds
//   rd_count         saturating count of completed reads
//   wr_count         saturating count of completed writes
// -----------------------------------------------------------------------------
module mem_port_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              avail,
  input  logic              r_en,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] ptr,
  input  logic [DATA_W-1:0] data_store,
  output logic [DATA_W-1:0] data_load,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] region_begin,
  output logic [ADDR_W-1:0] region_end,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_begin,
  input  logic [ADDR_W-1:0] cfg_end,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_RESP  = 3'd2,
    WRITE    = 3'd3,
    ERR_RESP = 3'd4
  } state_t;

  localparam int                DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] REGION_MAX = '1;
  localparam logic [15:0]       CNT_MAX    = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  state_t              r_state;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_region_begin;
  logic [ADDR_W-1:0]   r_region_end;
  logic [15:0]         r_rd_count;
  logic [15:0]         r_wr_count;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_q;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic w_idle;
  logic w_req_rd;
  logic w_req_wr;
  logic w_req_both;
  logic w_any_req;
  logic w_out_of_region;
  logic w_reject;
  logic w_cfg_ok;
  logic w_mem_we;
  logic w_mem_re;

  assign w_idle     = (r_state == IDLE);
  assign w_req_rd   = avail & r_en & ~w_en;
  assign w_req_wr   = avail & w_en & ~r_en;
  assign w_req_both = avail & r_en & w_en;
  assign w_any_req  = w_req_rd | w_req_wr | w_req_both;

`ifdef MEMRESP_BOUNDS_CHECK_EN
  assign w_out_of_region = (ptr < r_region_begin) || (ptr > r_region_end);
`else
  assign w_out_of_region = 1'b0;
`endif

  assign w_reject = w_req_both | ((w_req_rd | w_req_wr) & w_out_of_region);

  // A region load competes with any request presented in the same cycle,
  // including one that is about to be rejected; the request always wins.
  assign w_cfg_ok = cfg_we & ~w_any_req & (cfg_begin <= cfg_end);

  // Gating with rst lets a reset raised during WRITE suppress the commit.
  assign w_mem_we = (r_state == WRITE) & ~rst;
  assign w_mem_re = (r_state == RD_WAIT);

  // Responses are masked while rst is high so that a reset arriving in a
  // response cycle drops that response instead of leaking a done pulse.
  assign done         = r_done & ~rst;
  assign err          = r_err & ~rst;
  assign data_load    = ((r_state == RD_RESP) && !rst) ? r_rd_q : '0;
  assign region_begin = r_region_begin;
  assign region_end   = r_region_end;
  assign rd_count     = r_rd_count;
  assign wr_count     = r_wr_count;

  // Control FSM: request decode in IDLE, response sequencing elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_region_begin <= '0;
      r_region_end   <= REGION_MAX;
      r_rd_count     <= '0;
      r_wr_count     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_reject) begin
            r_state <= ERR_RESP;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else if (w_req_rd) begin
            r_state <= RD_WAIT;
          end else if (w_req_wr) begin
            r_state <= WRITE;
            r_done  <= 1'b1;
          end else if (w_cfg_ok) begin
            r_region_begin <= cfg_begin;
            r_region_end   <= cfg_end;
          end
        end
        RD_WAIT: begin
          r_state <= RD_RESP;
          r_done  <= 1'b1;
        end
        RD_RESP: begin
          r_state    <= IDLE;
          r_rd_count <= sat_inc(r_rd_count);
        end
        WRITE: begin
          r_state    <= IDLE;
          r_wr_count <= sat_inc(r_wr_count);
        end
        ERR_RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Request capture: address and write data held for the whole transaction.
  always_ff @(posedge clk) begin
    if (w_idle && (w_req_rd || w_req_wr) && !w_reject) begin
      r_ptr   <= ptr;
      r_wdata <= data_store;
    end
  end

  // SRAM: single port, write in WRITE, registered read in RD_WAIT.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= r_wdata;
    end else if (w_mem_re) begin
      r_rd_q <= r_mem[r_ptr];
    end
  end

endmodule
